// File: rtl/data_mem_arbiter.sv
// data_mem_arbiter: shares one single-port synchronous data RAM between the CPU
// memory stage (port 0) and the AES engine (port 1). Define ARB_FIXED_PRIO_EN for strict port-0 priority.
module data_mem_arbiter #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                m0_req,
  input  logic                m0_we,
  input  logic [DATA_W/8-1:0] m0_sel,
  input  logic [ADDR_W-1:0]   m0_addr,
  input  logic [DATA_W-1:0]   m0_wdata,
  output logic [DATA_W-1:0]   m0_rdata,
  output logic                m0_ack,
  output logic                m0_stall_req,
  input  logic                m1_req,
  input  logic                m1_we,
  input  logic [DATA_W/8-1:0] m1_sel,
  input  logic [ADDR_W-1:0]   m1_addr,
  input  logic [DATA_W-1:0]   m1_wdata,
  output logic [DATA_W-1:0]   m1_rdata,
  output logic                m1_ack,
  output logic                ram_ce,
  output logic                ram_we,
  output logic [DATA_W/8-1:0] ram_sel,
  output logic [ADDR_W-1:0]   ram_addr,
  output logic [DATA_W-1:0]   ram_wdata,
  input  logic [DATA_W-1:0]   ram_rdata,
  output logic                busy
);

  typedef enum logic [1:0] {IDLE, ISSUE, RESP} state_t;

  state_t            state, state_nx;
  logic              gnt, gnt_nx;
  logic              last, last_nx;
  logic [DATA_W-1:0] rdata0_q, rdata1_q;
  logic              gnt_we;
  logic              ack0, ack1;

  assign gnt_we = gnt ? m1_we : m0_we;

  // Acks are masked by rst so an access aborted in RESP is never reported done.
  assign ack0 = (state == RESP) && !gnt && !rst;
  assign ack1 = (state == RESP) &&  gnt && !rst;

  always_comb begin
    state_nx = state;
    gnt_nx   = gnt;
    last_nx  = last;
    case (state)
      IDLE: begin
        if (m0_req || m1_req) begin
`ifdef ARB_FIXED_PRIO_EN
          gnt_nx = !m0_req;
`else
          gnt_nx = (m0_req && m1_req) ? !last : m1_req;
`endif
          state_nx = ISSUE;
        end
      end
      ISSUE: state_nx = RESP;
      RESP: begin
        last_nx  = gnt;
        state_nx = IDLE;
`ifndef ARB_FIXED_PRIO_EN
        // Hand straight over to a waiting peer; the just-acked port's req is ignored.
        if (gnt ? m0_req : m1_req) begin
          gnt_nx   = !gnt;
          state_nx = ISSUE;
        end
`endif
      end
      default: state_nx = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= IDLE;
      gnt      <= 1'b0;
      last     <= 1'b1;
      rdata0_q <= '0;
      rdata1_q <= '0;
    end else begin
      state <= state_nx;
      gnt   <= gnt_nx;
      last  <= last_nx;
      if (state == RESP && !gnt_we) begin
        if (gnt) rdata1_q <= ram_rdata;
        else     rdata0_q <= ram_rdata;
      end
    end
  end

  always_comb begin
    ram_ce    = 1'b0;
    ram_we    = 1'b0;
    ram_sel   = '0;
    ram_addr  = '0;
    ram_wdata = '0;
    if (state == ISSUE) begin
      ram_ce    = 1'b1;
      ram_we    = gnt ? m1_we    : m0_we;
      ram_sel   = gnt ? m1_sel   : m0_sel;
      ram_addr  = gnt ? m1_addr  : m0_addr;
      ram_wdata = gnt ? m1_wdata : m0_wdata;
    end
  end

  // Writes show the held read data during their ack so rdata never glitches.
  assign m0_rdata     = (ack0 && !m0_we) ? ram_rdata : rdata0_q;
  assign m1_rdata     = (ack1 && !m1_we) ? ram_rdata : rdata1_q;
  assign m0_ack       = ack0;
  assign m1_ack       = ack1;
  assign m0_stall_req = m0_req && !ack0 && !rst;
  assign busy         = (state != IDLE);

endmodule

// File: tb/tb_data_mem_arbiter.sv
// Bench for data_mem_arbiter: directed steps then random traffic, checked against
// a transaction-level schedule/memory model. Honours ARB_FIXED_PRIO_EN.
module tb_data_mem_arbiter;

`ifdef ARB_FIXED_PRIO_EN
  localparam bit FIXED = 1'b1;
`else
  localparam bit FIXED = 1'b0;
`endif

  logic        clk, rst;
  logic        m0_req, m0_we, m0_ack, m0_stall_req, m1_req, m1_we, m1_ack;
  logic [3:0]  m0_sel, m1_sel, ram_sel;
  logic [31:0] m0_addr, m0_wdata, m0_rdata, m1_addr, m1_wdata, m1_rdata;
  logic        ram_ce, ram_we, busy;
  logic [31:0] ram_addr, ram_wdata, ram_rdata;

  logic        req_b [2];
  logic        we_b  [2];
  logic [3:0]  sel_b [2];
  logic [31:0] addr_b[2];
  logic [31:0] wd_b  [2];

  assign m0_req = req_b[0];  assign m0_we = we_b[0];  assign m0_sel = sel_b[0];
  assign m0_addr = addr_b[0]; assign m0_wdata = wd_b[0];
  assign m1_req = req_b[1];  assign m1_we = we_b[1];  assign m1_sel = sel_b[1];
  assign m1_addr = addr_b[1]; assign m1_wdata = wd_b[1];

  data_mem_arbiter #(.ADDR_W(32), .DATA_W(32)) dut (
    .clk(clk), .rst(rst),
    .m0_req(m0_req), .m0_we(m0_we), .m0_sel(m0_sel), .m0_addr(m0_addr), .m0_wdata(m0_wdata),
    .m0_rdata(m0_rdata), .m0_ack(m0_ack), .m0_stall_req(m0_stall_req),
    .m1_req(m1_req), .m1_we(m1_we), .m1_sel(m1_sel), .m1_addr(m1_addr), .m1_wdata(m1_wdata),
    .m1_rdata(m1_rdata), .m1_ack(m1_ack),
    .ram_ce(ram_ce), .ram_we(ram_we), .ram_sel(ram_sel), .ram_addr(ram_addr),
    .ram_wdata(ram_wdata), .ram_rdata(ram_rdata), .busy(busy)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  function automatic logic [31:0] init_val(input int unsigned i);
    logic [7:0] b;
    b = i[7:0];
    return (i == 4) ? 32'hDEADBEEF : {b, 8'h5A, ~b, 8'hC3};
  endfunction

  function automatic logic [7:0] idx(input logic [31:0] a);
    return a[9:2];
  endfunction

  function automatic logic [31:0] merge(input logic [31:0] old, input logic [31:0] wd,
                                        input logic [3:0] sel);
    logic [31:0] r;
    r = old;
    for (int b = 0; b < 4; b++) if (sel[b]) r[8*b +: 8] = wd[8*b +: 8];
    return r;
  endfunction

  // Behavioural RAM: read data appears the cycle after a read access.
  logic [31:0] ram_mem [256];
  bit          ram_loaded = 1'b0;
  always @(posedge clk) begin
    if (!ram_loaded) begin
      for (int i = 0; i < 256; i++) ram_mem[i] <= init_val(i);
      ram_loaded <= 1'b1;
      ram_rdata  <= '0;
    end else if (ram_ce === 1'b1) begin
      if (ram_we) ram_mem[idx(ram_addr)] <= merge(ram_mem[idx(ram_addr)], ram_wdata, ram_sel);
      else        ram_rdata <= ram_mem[idx(ram_addr)];
    end
  end

  // Reference model: scheduled ack cycle per port plus a golden memory image.
  logic [31:0] gold [256];
  int          cyc;
  int          ack_due [2];
  bit          last_p;
  logic [31:0] q_m [2];
  logic [31:0] rdval [2];
  bit          we_at [2];
  bit          e_ack [2];
  int          errors = 0;
  int          checks = 0;

  typedef enum {P_DROP, P_HOLD, P_RAND} pol_t;
  pol_t pol;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic settle_and_check();
    int ip, k;
    logic [31:0] e_rd [2];
    #2;
    ip = -1;
    for (int p = 0; p < 2; p++) begin
      e_ack[p] = (ack_due[p] == cyc) && !rst;
      if (ack_due[p] == cyc + 1) ip = p;
      e_rd[p] = (e_ack[p] && !we_at[p]) ? rdval[p] : q_m[p];
    end
    k = (ip < 0) ? 0 : ip;
    chk("m0_ack", m0_ack, e_ack[0]);
    chk("m1_ack", m1_ack, e_ack[1]);
    chk("m0_rdata", m0_rdata, e_rd[0]);
    chk("m1_rdata", m1_rdata, e_rd[1]);
    chk("m0_stall", m0_stall_req, req_b[0] && !e_ack[0] && !rst);
    chk("busy", busy, (ack_due[0] >= cyc) || (ack_due[1] >= cyc));
    chk("ram_ce", ram_ce, ip >= 0);
    chk("ram_we", ram_we, (ip >= 0) ? we_b[k] : 1'b0);
    chk("ram_sel", ram_sel, (ip >= 0) ? sel_b[k] : 4'h0);
    chk("ram_addr", ram_addr, (ip >= 0) ? addr_b[k] : 32'h0);
    chk("ram_wdata", ram_wdata, (ip >= 0) ? wd_b[k] : 32'h0);
  endtask

  task automatic new_req(input int p);
    req_b[p]  = 1'b1;
    we_b[p]   = 1'($urandom_range(1, 0));
    sel_b[p]  = we_b[p] ? 4'($urandom_range(15, 0)) : 4'h0;
    addr_b[p] = 32'($urandom_range(15, 0)) << 2;
    wd_b[p]   = $urandom;
  endtask

  task automatic advance();
    bit idle;
    int acked, g;
    idle = !((ack_due[0] >= cyc) || (ack_due[1] >= cyc));
    if (rst) begin
      ack_due = '{-1, -1};
      last_p  = 1'b1;
      q_m     = '{32'h0, 32'h0};
    end else begin
      for (int p = 0; p < 2; p++) if (ack_due[p] == cyc + 1) begin
        we_at[p] = we_b[p];
        if (we_b[p]) gold[idx(addr_b[p])] = merge(gold[idx(addr_b[p])], wd_b[p], sel_b[p]);
        else         rdval[p] = gold[idx(addr_b[p])];
      end
      acked = -1;
      for (int p = 0; p < 2; p++) if (ack_due[p] == cyc) begin
        acked = p;
        ack_due[p] = -1;
      end
      if (acked >= 0) begin
        if (!we_at[acked]) q_m[acked] = rdval[acked];
        last_p = (acked == 1);
        if (!FIXED && req_b[1-acked]) ack_due[1-acked] = cyc + 2;
      end else if (idle && (req_b[0] || req_b[1])) begin
        if (req_b[0] && req_b[1]) g = FIXED ? 0 : (last_p ? 0 : 1);
        else                      g = req_b[0] ? 0 : 1;
        ack_due[g] = cyc + 2;
      end
    end
    @(posedge clk);
    #1;
    cyc++;
    for (int p = 0; p < 2; p++) begin
      if (e_ack[p]) begin
        if (pol == P_DROP) req_b[p] = 1'b0;
        else if (pol == P_RAND) begin
          if ($urandom_range(1, 0) == 1) new_req(p);
          else req_b[p] = 1'b0;
        end
      end else if (pol == P_RAND && !req_b[p] && $urandom_range(2, 0) == 0) begin
        new_req(p);
      end
    end
  endtask

  task automatic step();
    settle_and_check();
    advance();
  endtask

  task automatic drain(input string tag);
    int n;
    n = 0;
    pol = P_DROP;
    while ((req_b[0] || req_b[1] || ack_due[0] >= cyc || ack_due[1] >= cyc) && n < 40) begin
      step();
      n++;
    end
    chk(tag, n >= 40, 1'b0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: observed=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int n0, n1;
    for (int i = 0; i < 256; i++) gold[i] = init_val(i);
    cyc = 0; ack_due = '{-1, -1}; last_p = 1'b1; q_m = '{32'h0, 32'h0};
    rdval = '{32'h0, 32'h0}; we_at = '{1'b0, 1'b0}; e_ack = '{1'b0, 1'b0};
    pol = P_DROP;
    rst = 1'b1;
    req_b[0] = 1'b1; we_b[0] = 1'b0; sel_b[0] = 4'h0; addr_b[0] = 32'h10;  wd_b[0] = 32'hFFFF0000;
    req_b[1] = 1'b1; we_b[1] = 1'b1; sel_b[1] = 4'hF; addr_b[1] = 32'h200; wd_b[1] = 32'h01234567;
    @(posedge clk);
    #1;

    // Reset held with both ports requesting.
    repeat (2) begin
      settle_and_check();
      chk("d_rst_ce", ram_ce, 1'b0);
      chk("d_rst_stall", m0_stall_req, 1'b0);
      chk("d_rst_busy", busy, 1'b0);
      chk("d_rst_rdata", m0_rdata, 32'h0);
      advance();
    end
    rst = 1'b0;

    // Simultaneous requests: port 0 read of 0x10 wins, port 1 write follows.
    settle_and_check();
    chk("d_t0_stall", m0_stall_req, 1'b1);
    advance();
    settle_and_check();
    chk("d_t1_ce", ram_ce, 1'b1);
    chk("d_t1_addr", ram_addr, 32'h10);
    chk("d_t1_we", ram_we, 1'b0);
    chk("d_t1_stall", m0_stall_req, 1'b1);
    advance();
    settle_and_check();
    chk("d_t2_ack", m0_ack, 1'b1);
    chk("d_t2_rdata", m0_rdata, 32'hDEADBEEF);
    chk("d_t2_stall", m0_stall_req, 1'b0);
    advance();
    settle_and_check();
    chk("d_t3_hold", m0_rdata, 32'hDEADBEEF);
    chk("d_t3_ce", ram_ce, !FIXED);
    chk("d_t3_we", ram_we, !FIXED);
    advance();
    settle_and_check();
    chk("d_t4_m1ack", m1_ack, !FIXED);
    chk("d_t4_m1rdata", m1_rdata, 32'h0);
    advance();
    drain("d_first_drain");

    // Both ports requesting continuously.
    pol = P_HOLD;
    req_b[0] = 1'b1; we_b[0] = 1'b0; sel_b[0] = 4'h0; addr_b[0] = 32'h8;
    req_b[1] = 1'b1; we_b[1] = 1'b0; sel_b[1] = 4'hF; addr_b[1] = 32'h200;
    n0 = 0; n1 = 0;
    repeat (13) begin
      settle_and_check();
      if (m0_ack === 1'b1) n0++;
      if (m1_ack === 1'b1) n1++;
      advance();
    end
    chk("d_cont_m0_acks", n0, FIXED ? 4 : 3);
    chk("d_cont_m1_acks", n1, FIXED ? 0 : 3);
    drain("d_cont_drain");

    // Reset during ISSUE aborts the access; request is regranted afterwards.
    req_b[0] = 1'b1; we_b[0] = 1'b0; sel_b[0] = 4'h0; addr_b[0] = 32'h20;
    step();
    rst = 1'b1;
    settle_and_check();
    chk("d_ri_ce", ram_ce, 1'b1);
    advance();
    rst = 1'b0;
    settle_and_check();
    chk("d_ri_ack", m0_ack, 1'b0);
    chk("d_ri_ce_off", ram_ce, 1'b0);
    chk("d_ri_busy", busy, 1'b0);
    chk("d_ri_rdata", m0_rdata, 32'h0);
    advance();
    settle_and_check();
    chk("d_ri_regrant", ram_ce, 1'b1);
    advance();
    settle_and_check();
    chk("d_ri_ack2", m0_ack, 1'b1);
    chk("d_ri_data", m0_rdata, init_val(8));
    advance();
    drain("d_ri_drain");

    // Random traffic on both ports.
    pol = P_RAND;
    repeat (400) step();
    drain("d_rand_drain");

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
